// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants for the program loader and the main decoder.
// Holds the major opcodes, the loader's request class codes, the loader FSM
// state type and the field-level request bundle handed to the word packer.
package riscv_pkg;

  // Major opcodes (bits 6:0 of the instruction word)
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Request class codes; 5..7 are illegal
  localparam logic [2:0] CLS_R      = 3'd0;
  localparam logic [2:0] CLS_I      = 3'd1;
  localparam logic [2:0] CLS_LOAD   = 3'd2;
  localparam logic [2:0] CLS_STORE  = 3'd3;
  localparam logic [2:0] CLS_BRANCH = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FULL = 2'd2
  } state_e;

  typedef struct packed {
    logic [2:0]  cls;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } instr_req_t;

  // slli/srli/srai carry a 5-bit shamt plus funct7 instead of a 12-bit imm
  function automatic logic is_shift(input logic [2:0] f3);
    return (f3 == 3'b001) || (f3 == 3'b101);
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I word packer.
//   req_i     : class + register/funct/immediate fields
//   word_o    : assembled 32-bit instruction (0 when illegal)
//   illegal_o : class 5..7, or a branch with an odd offset
module instr_pack
  import riscv_pkg::*;
(
  input  instr_req_t  req_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  // Immediate bits above the widest encoded field (branch, bit 12) are ignored
  logic unused_imm;
  assign unused_imm = ^req_i.imm[31:13];

  always_comb begin
    word_o    = '0;
    illegal_o = 1'b0;
    case (req_i.cls)
      CLS_R: word_o = {1'b0, req_i.funct7b5, 5'b00000, req_i.rs2, req_i.rs1,
                       req_i.funct3, req_i.rd, OP_R};
      CLS_I: begin
        if (is_shift(req_i.funct3))
          word_o = {1'b0, req_i.funct7b5, 5'b00000, req_i.imm[4:0], req_i.rs1,
                    req_i.funct3, req_i.rd, OP_I};
        else
          word_o = {req_i.imm[11:0], req_i.rs1, req_i.funct3, req_i.rd, OP_I};
      end
      CLS_LOAD: word_o = {req_i.imm[11:0], req_i.rs1, req_i.funct3, req_i.rd, OP_LOAD};
      CLS_STORE: word_o = {req_i.imm[11:5], req_i.rs2, req_i.rs1, req_i.funct3,
                           req_i.imm[4:0], OP_STORE};
      CLS_BRANCH: begin
        // Branch offsets are halfword multiples; bit 0 has no encoding
        illegal_o = req_i.imm[0];
        if (!req_i.imm[0])
          word_o = {req_i.imm[12], req_i.imm[10:5], req_i.rs2, req_i.rs1,
                    req_i.funct3, req_i.imm[4:1], req_i.imm[11], OP_BRANCH};
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/prog_encoder.sv
// Instruction encoder / program loader. Accepts field-level requests over a
// valid/ready handshake, packs them into RV32I words and writes them to
// consecutive instruction-memory words, one cycle after acceptance.
//   clk, rst        : clock, async active-low reset
//   start, stop     : control pulses (start clears count/err and runs)
//   in_*            : request handshake and fields
//   wr_en/addr/data : registered instruction-memory write port
//   count, full     : words written since start, memory-full flag
//   err             : sticky illegal-request flag
module prog_encoder
  import riscv_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          in_class,
  input  logic [2:0]          in_funct3,
  input  logic                in_funct7b5,
  input  logic [4:0]          in_rd,
  input  logic [4:0]          in_rs1,
  input  logic [4:0]          in_rs2,
  input  logic [31:0]         in_imm,
  output logic                wr_en,
  output logic [31:0]         wr_addr,
  output logic [31:0]         wr_data,
  output logic [DEPTH_LOG2:0] count,
  output logic                full,
  output logic                err
);

  localparam int ADDR_PAD = 30 - DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CNT_MAX  = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] CNT_LAST = {1'b0, {DEPTH_LOG2{1'b1}}};
  localparam logic [DEPTH_LOG2:0] CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  err_q, err_d;
  logic                  wr_en_q, wr_en_d;
  logic [31:0]           wr_addr_q, wr_addr_d;
  logic [31:0]           wr_data_q, wr_data_d;

  instr_req_t  req;
  logic [31:0] word;
  logic        illegal;
  logic        accept;

  assign req = '{cls: in_class, funct3: in_funct3, funct7b5: in_funct7b5,
                 rd: in_rd, rs1: in_rs1, rs2: in_rs2, imm: in_imm};

  instr_pack u_pack (
    .req_i     (req),
    .word_o    (word),
    .illegal_o (illegal)
  );

  assign in_ready = (state_q == ST_RUN);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    err_d     = err_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (start) begin
      // start outranks stop and supersedes any request handshaking this cycle
      state_d = ST_RUN;
      count_d = '0;
      err_d   = 1'b0;
    end else begin
      if (accept) begin
        if (illegal) begin
          // Consumed but never written; only the sticky flag records it
          err_d = 1'b1;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = {{ADDR_PAD{1'b0}}, count_q[DEPTH_LOG2-1:0], 2'b00};
          wr_data_d = word;
          count_d   = count_q + CNT_ONE;
          if (count_q == CNT_LAST) state_d = ST_FULL;
        end
      end
      // The write launched above (or one already pending) still goes out
      if (stop && state_q != ST_IDLE) state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      err_q     <= err_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign count   = count_q;
  assign full    = (count_q == CNT_MAX);
  assign err     = err_q;

endmodule

// File: tb/tb_prog_encoder.sv
module tb_prog_encoder;
  localparam int DL  = 2;
  localparam int MAX = 1 << DL;

  logic        clk = 1'b0;
  logic        rst, start, stop, in_valid, in_ready;
  logic [2:0]  in_class, in_funct3;
  logic        in_funct7b5;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        wr_en, full, err;
  logic [31:0] wr_addr, wr_data;
  logic [DL:0] count;

  prog_encoder #(.DEPTH_LOG2(DL)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class),
    .in_funct3(in_funct3), .in_funct7b5(in_funct7b5), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .count(count), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  wr_t exp_q[$];

  // Reference model: "running" flag, words accepted, sticky error
  bit          m_on;
  int          m_cnt;
  bit          m_err;
  bit          use_lit;
  logic [31:0] lit_word;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // RV32I field placement from the ISA layout, using shifts and masks
  function automatic bit ref_word(input logic [31:0] c, f3, b5, rd, rs1, rs2, imm,
                                  output logic [31:0] w);
    bit ok = 1'b1;
    w = 32'h0;
    case (c)
      0: w = 32'h33 | (rd << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20) | (b5 << 30);
      1: if (f3 == 1 || f3 == 5)
           w = 32'h13 | (rd << 7) | (f3 << 12) | (rs1 << 15) | ((imm & 31) << 20) | (b5 << 30);
         else
           w = 32'h13 | (rd << 7) | (f3 << 12) | (rs1 << 15) | ((imm & 32'hfff) << 20);
      2: w = 32'h03 | (rd << 7) | (f3 << 12) | (rs1 << 15) | ((imm & 32'hfff) << 20);
      3: w = 32'h23 | ((imm & 31) << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20)
             | (((imm >> 5) & 32'h7f) << 25);
      4: begin
        ok = (imm % 2) == 0;
        w = 32'h63 | (((imm >> 11) & 1) << 7) | (((imm >> 1) & 15) << 8) | (f3 << 12)
            | (rs1 << 15) | (rs2 << 20) | (((imm >> 5) & 63) << 25) | (((imm >> 12) & 1) << 31);
      end
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  task automatic model_reset();
    m_on = 0; m_cnt = 0; m_err = 0;
    exp_q.delete();
  endtask

  // Called just after each rising edge with the inputs that edge sampled
  task automatic model_update();
    bit acc, ok;
    logic [31:0] w;
    if (!rst) return;
    acc = in_valid && m_on && (m_cnt != MAX);
    if (start) begin
      m_on = 1; m_cnt = 0; m_err = 0;
    end else begin
      if (acc) begin
        ok = ref_word(32'(in_class), 32'(in_funct3), 32'(in_funct7b5), 32'(in_rd),
                      32'(in_rs1), 32'(in_rs2), in_imm, w);
        if (ok) begin
          if (use_lit) w = lit_word;
          exp_q.push_back('{addr: 32'(m_cnt * 4), data: w});
          m_cnt++;
        end else m_err = 1;
      end
      if (stop) m_on = 0;
    end
  endtask

  // Monitor: status every cycle, scoreboard pop whenever a write appears
  always @(negedge clk) begin
    wr_t e;
    chk("in_ready", 32'(in_ready), 32'(m_on && m_cnt != MAX));
    chk("count", 32'(count), 32'(m_cnt));
    chk("full", 32'(full), 32'(m_cnt == MAX));
    chk("err", 32'(err), 32'(m_err));
    chk("wr_en", 32'(wr_en), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (wr_en) begin
        chk("wr_addr", wr_addr, e.addr);
        chk("wr_data", wr_data, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    start = 0; stop = 0; use_lit = 0;
  endtask

  task automatic req(input logic [2:0] c, f3, input logic b5, input logic [4:0] rd, rs1, rs2,
                     input logic [31:0] imm);
    in_valid = 1; in_class = c; in_funct3 = f3; in_funct7b5 = b5;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
  endtask

  task automatic lit(input logic [31:0] w);
    use_lit = 1; lit_word = w;
  endtask

  task automatic do_start(input bit with_stop);
    in_valid = 0; start = 1; stop = with_stop;
    tick();
  endtask

  task automatic rand_req();
    logic [2:0] c;
    logic [31:0] imm;
    c = ($urandom % 8 == 7) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
    imm = $urandom;
    if (c == 3'd4 && $urandom % 4 != 0) imm[0] = 1'b0;
    req(c, 3'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), imm);
    in_valid = ($urandom % 4 != 0);
  endtask

  initial begin
    rst = 0; start = 0; stop = 0; use_lit = 0; lit_word = '0;
    req(3'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
    in_valid = 0;
    model_reset();
    @(negedge clk);
    chk("rst wr_addr", wr_addr, 32'h0);
    chk("rst wr_data", wr_data, 32'h0);
    rst = 1;

    // Request without start is ignored
    req(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'h0);
    repeat (2) tick();

    // R add x3,x1,x2
    do_start(0);
    req(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'h0); lit(32'h002081B3); tick();
    in_valid = 0; tick();

    // LOAD then STORE back-to-back
    do_start(0);
    req(3'd2, 3'd2, 1'b0, 5'd5, 5'd0, 5'd0, 32'd8);   lit(32'h00802283); tick();
    req(3'd3, 3'd2, 1'b0, 5'd0, 5'd2, 5'd6, 32'd12);  lit(32'h00612623); tick();
    in_valid = 0; tick();

    // BRANCH imm=-4 legal, imm=-3 illegal
    do_start(0);
    req(3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, -32'sd4); lit(32'hFE208EE3); tick();
    req(3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, -32'sd3); tick();
    in_valid = 0; tick();

    // Fill memory, fifth request held, start clears
    do_start(0);
    req(3'd1, 3'd0, 1'b0, 5'd7, 5'd4, 5'd0, 32'd100);
    repeat (7) tick();
    in_valid = 0; tick();
    do_start(0);
    tick();

    // Illegal class: sticky err across legal writes, cleared by start
    req(3'd6, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'h0); tick();
    req(3'd1, 3'd5, 1'b1, 5'd9, 5'd8, 5'd0, 32'h3); tick();
    req(3'd0, 3'd7, 1'b0, 5'd1, 5'd2, 5'd3, 32'h0); tick();
    in_valid = 0; tick();
    do_start(0);
    do_start(1);   // start + stop together: still running
    tick();

    // Reset right after an accept drops the pending write
    req(3'd0, 3'd4, 1'b0, 5'd10, 5'd11, 5'd12, 32'h0);
    @(posedge clk);
    model_update();
    #1 rst = 0;
    model_reset();
    @(negedge clk);
    chk("midrst wr_addr", wr_addr, 32'h0);
    chk("midrst wr_data", wr_data, 32'h0);
    rst = 1;
    repeat (3) tick();   // valid held, not accepted until start
    do_start(0);
    repeat (2) tick();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      case ($urandom % 20)
        0: begin in_valid = 0; start = 1; stop = 1'($urandom); end
        1: begin in_valid = 0; stop = 1; end
        default: rand_req();
      endcase
      tick();
    end
    in_valid = 0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
